// File: rtl/spi_display_pkg.sv
// Shared constants for the SPI display sequencer: opcodes, FSM encoding
// and default widths.
package spi_display_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ARG_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        OP_WRITE_DATA  = 2'b00,
        OP_WRITE_CMD   = 2'b01,
        OP_DELAY       = 2'b10,
        OP_RESET_PULSE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_DELAY    = 3'd3,
        ST_RSTPULSE = 3'd4
    } state_e;

endpackage

// File: rtl/spi_display_sequencer_tick_down_counter.sv
// Loadable down-counter stepped by the serial-clock strobe; parks at zero
// instead of wrapping.
module tick_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && !zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/spi_display_sequencer.sv
// Instruction sequencer for an SPI display: byte writes (data/command),
// strobe-counted delays and hardware reset pulses.
//
//   state       | meaning
//   ------------+--------------------------------------------------
//   ST_IDLE     | ready for an instruction, cs high
//   ST_LOAD     | cs low, waiting for the strobe that loads the shifter
//   ST_SHIFT    | cs low, counting DATA_W shift strobes
//   ST_DELAY    | counting down arg strobes, cs high
//   ST_RSTPULSE | as ST_DELAY with resN held low
module spi_display_sequencer
    import spi_display_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ARG_W  = ARG_W_DEFAULT,
    parameter int CNT_W  = ARG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclkPosEdge,
    input  logic              instrValid,
    input  logic [ARG_W+1:0]  instr,
    output logic              instrReady,
    output logic              cs,
    output logic              dc,
    output logic              pcEn,
    output logic [DATA_W-1:0] parallelData,
    output logic              resN,
    output logic              busy
);

    state_e             state_q, state_d;
    op_e                op;
    logic [DATA_W-1:0]  data_q;
    logic               dc_q;
    logic               rdy_q;
    logic               accept;
    logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [CNT_W-1:0]   cnt_load_val, cnt_val;

    assign op         = op_e'(instr[ARG_W+1:ARG_W]);
    assign instrReady = rdy_q && (state_q == ST_IDLE);
    assign accept     = instrValid && instrReady;
    assign cnt_last   = (cnt_val == CNT_W'(1));

    tick_down_counter #(.W(CNT_W)) u_tick_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = CNT_W'(instr[ARG_W-1:0]);
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_WRITE_DATA, OP_WRITE_CMD: state_d = ST_LOAD;
                        OP_DELAY: begin
                            state_d  = ST_DELAY;
                            cnt_load = 1'b1;
                        end
                        default: begin
                            state_d  = ST_RSTPULSE;
                            cnt_load = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (sclkPosEdge) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(DATA_W);
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT, ST_DELAY, ST_RSTPULSE: begin
                cnt_dec = sclkPosEdge;
                // a zero count only occurs for arg = 0: leave without a strobe
                if (cnt_zero || (sclkPosEdge && cnt_last)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dc_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (accept && (op == OP_WRITE_DATA || op == OP_WRITE_CMD)) begin
                data_q <= instr[DATA_W-1:0];
                dc_q   <= (op == OP_WRITE_DATA);
            end
        end
    end

    assign cs           = !(state_q == ST_LOAD || state_q == ST_SHIFT);
    assign pcEn         = (state_q == ST_LOAD) && sclkPosEdge;
    assign resN         = (state_q != ST_RSTPULSE);
    assign busy         = (state_q != ST_IDLE);
    assign dc           = dc_q;
    assign parallelData = data_q;

endmodule

// File: tb/tb_spi_display_sequencer.sv
// Directed bench for spi_display_sequencer: default 8/16 instance plus a
// 16/20 instance for the wide configuration.
module tb_spi_display_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sclk_a, iv_a, sclk_b, iv_b;
    logic [17:0] instr_a;
    logic [21:0] instr_b;
    logic        rdy_a, cs_a, dc_a, pc_a, resn_a, busy_a;
    logic        rdy_b, cs_b, dc_b, pc_b, resn_b, busy_b;
    logic [7:0]  pd_a;
    logic [15:0] pd_b;

    spi_display_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .sclkPosEdge(sclk_a), .instrValid(iv_a),
        .instr(instr_a), .instrReady(rdy_a), .cs(cs_a), .dc(dc_a), .pcEn(pc_a),
        .parallelData(pd_a), .resN(resn_a), .busy(busy_a)
    );

    spi_display_sequencer #(.DATA_W(16), .ARG_W(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .sclkPosEdge(sclk_b), .instrValid(iv_b),
        .instr(instr_b), .instrReady(rdy_b), .cs(cs_b), .dc(dc_b), .pcEn(pc_b),
        .parallelData(pd_b), .resN(resn_b), .busy(busy_b)
    );

    logic        sel;
    logic        o_rdy, o_cs, o_dc, o_pc, o_resn, o_busy;
    logic [15:0] o_pd;
    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_cs   = sel ? cs_b   : cs_a;
    assign o_dc   = sel ? dc_b   : dc_a;
    assign o_pc   = sel ? pc_b   : pc_a;
    assign o_resn = sel ? resn_b : resn_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_pd   = sel ? pd_b   : {8'h00, pd_a};

    int n_cmp = 0;
    int n_err = 0;
    int m_strobes, m_pcen, m_busy, m_csl, m_resn_cyc, m_resn_str;
    logic [15:0] m_pd;
    logic        m_dc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sclk(input logic v);
        if (sel) sclk_b = v; else sclk_a = v;
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [19:0] arg);
        if (sel) begin iv_b = v; instr_b = {op, arg}; end
        else     begin iv_a = v; instr_a = {op, arg[15:0]}; end
    endtask

    // Issue one instruction from IDLE (strobe coincident with acceptance)
    // and record what happens while busy.
    task automatic run_op(input logic [1:0] op, input logic [19:0] arg, input int max_cyc,
                          input logic every, input logic hold_valid);
        logic timeout;
        m_strobes = 0; m_pcen = 0; m_busy = 0; m_csl = 0;
        m_resn_cyc = 0; m_resn_str = 0; m_pd = 'x; m_dc = 1'bx;
        chk("idle_ready", o_rdy, 1);
        chk("idle_cs", o_cs, 1);
        set_in(1'b1, op, arg);
        set_sclk(1'b1);
        @(posedge clk); #1;
        set_in(hold_valid, 2'b00, 20'h5A5A5);
        chk("accept_busy", o_busy, 1);
        timeout = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            set_sclk(every || (i % 2 == 1));
            #3;
            if (!o_busy) begin
                timeout = 1'b0;
                break;
            end
            m_busy++;
            if (sel ? sclk_b : sclk_a) m_strobes++;
            if (o_pc) begin m_pcen++; m_pd = o_pd; end
            if (!o_cs) m_csl++;
            if (!o_resn) begin
                m_resn_cyc++;
                if (sel ? sclk_b : sclk_a) m_resn_str++;
            end
            m_dc = o_dc;
            @(posedge clk); #1;
        end
        set_in(1'b0, 2'b00, 20'h0);
        set_sclk(1'b0);
        chk("op_timeout", timeout, 0);
    endtask

    initial begin
        sel = 1'b0;
        rst_n = 1'b0;
        sclk_a = 1'b0; iv_a = 1'b0; instr_a = '0;
        sclk_b = 1'b0; iv_b = 1'b0; instr_b = '0;
        #2;
        chk("rst_cs", cs_a, 1);
        chk("rst_dc", dc_a, 0);
        chk("rst_pcen", pc_a, 0);
        chk("rst_resn", resn_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", rdy_a, 0);
        chk("rst_pdata", pd_a, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", rdy_a, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", rdy_a, 1);

        // write data 0xAA, then a command byte straight after
        run_op(2'b00, 20'h000AA, 200, 1'b0, 1'b0);
        chk("wd_strobes", m_strobes, 9);
        chk("wd_pcen", m_pcen, 1);
        chk("wd_pdata", m_pd, 16'h00AA);
        chk("wd_dc", m_dc, 1);
        chk("wd_cs_low", m_csl, 18);
        chk("wd_busy", m_busy, 18);
        run_op(2'b01, 20'h00033, 200, 1'b0, 1'b0);
        chk("wc_strobes", m_strobes, 9);
        chk("wc_pcen", m_pcen, 1);
        chk("wc_pdata", m_pd, 16'h0033);
        chk("wc_dc", m_dc, 0);
        chk("wc_cs_low", m_csl, 18);

        // delays
        run_op(2'b10, 20'd5, 200, 1'b0, 1'b0);
        chk("dly5_strobes", m_strobes, 5);
        chk("dly5_busy", m_busy, 10);
        chk("dly5_pcen", m_pcen, 0);
        chk("dly5_cs_low", m_csl, 0);
        chk("dly5_dc_hold", o_dc, 0);
        run_op(2'b10, 20'd0, 200, 1'b0, 1'b0);
        chk("dly0_busy", m_busy, 1);
        chk("dly0_strobes", m_strobes, 0);

        // reset pulse with a write held on instrValid throughout
        run_op(2'b11, 20'd3, 200, 1'b0, 1'b1);
        chk("rp3_resn_strobes", m_resn_str, 3);
        chk("rp3_resn_cycles", m_resn_cyc, 6);
        chk("rp3_busy", m_busy, 6);
        chk("rp3_resn_after", o_resn, 1);
        chk("rp3_pcen", m_pcen, 0);
        @(posedge clk); #1;
        chk("rp3_ignored_instr", o_busy, 0);
        run_op(2'b11, 20'd0, 200, 1'b0, 1'b0);
        chk("rp0_resn_cycles", m_resn_cyc, 1);
        chk("rp0_busy", m_busy, 1);

        // reset during the 4th shift strobe
        set_in(1'b1, 2'b00, 20'h00096);
        sclk_a = 1'b0;
        @(posedge clk); #1;
        set_in(1'b0, 2'b00, 20'h0);
        sclk_a = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_shift_cs", cs_a, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", cs_a, 1);
        chk("mid_rst_pcen", pc_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ready", rdy_a, 0);
        chk("mid_rst_dc", dc_a, 0);
        #2;
        rst_n = 1'b1;
        sclk_a = 1'b0;
        @(posedge clk); #1;
        chk("mid_rel_ready", rdy_a, 1);
        run_op(2'b00, 20'h0005C, 200, 1'b0, 1'b0);
        chk("post_rst_strobes", m_strobes, 9);
        chk("post_rst_pcen", m_pcen, 1);
        chk("post_rst_pdata", m_pd, 16'h005C);

        // reset during a reset pulse
        set_in(1'b1, 2'b11, 20'd10);
        sclk_a = 1'b1;
        @(posedge clk); #1;
        set_in(1'b0, 2'b00, 20'h0);
        @(posedge clk); #1;
        chk("pulse_resn_low", resn_a, 0);
        rst_n = 1'b0;
        #1;
        chk("pulse_rst_resn", resn_a, 1);
        chk("pulse_rst_busy", busy_a, 0);
        #2;
        rst_n = 1'b1;
        sclk_a = 1'b0;
        @(posedge clk); #1;

        // wide configuration: 16-bit bytes, counter wider than 16 bits
        sel = 1'b1;
        run_op(2'b00, 20'h0BEEF, 200, 1'b0, 1'b0);
        chk("w16_strobes", m_strobes, 17);
        chk("w16_pcen", m_pcen, 1);
        chk("w16_pdata", m_pd, 16'hBEEF);
        chk("w16_dc", m_dc, 1);
        run_op(2'b10, 20'h10001, 70000, 1'b1, 1'b0);
        chk("d20_strobes", m_strobes, 32'h10001);
        chk("d20_busy", m_busy, 32'h10001);
        chk("d20_pcen", m_pcen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_display_sequencer.md
SPI_DISPLAY_SEQUENCER -- requirements
Module: spi_display_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one serial write (bits per byte).
REQ-002 SHALL have parameter ARG_W, default 16, instruction argument width; ARG_W >= DATA_W is a legal-configuration requirement.
REQ-003 SHALL have parameter CNT_W, default ARG_W, width of the internal tick counter.
REQ-004 clk  in  1  single system clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 sclkPosEdge  in  1  one-clk-wide strobe marking each serial-clock rising edge.
REQ-007 instrValid  in  1  instruction present on instr.
REQ-008 instr  in  2+ARG_W  op = instr[ARG_W+1:ARG_W], arg = instr[ARG_W-1:0].
REQ-009 instrReady  out  1  sequencer accepts instr this cycle.
REQ-010 cs  out  1  display chip select, active low.
REQ-011 dc  out  1  1 = data, 0 = command.
REQ-012 pcEn  out  1  parallel-load strobe to the shift register.
REQ-013 parallelData  out  DATA_W  byte to load, equal to registered arg[DATA_W-1:0].
REQ-014 resN  out  1  display hardware reset, active low.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Opcodes SHALL be: 00 WRITE_DATA, 01 WRITE_CMD, 10 DELAY, 11 RESET_PULSE.
REQ-017 States SHALL be IDLE, LOAD, SHIFT, DELAY, RSTPULSE.
REQ-018 instrReady SHALL equal (state == IDLE); an instruction is accepted on a posedge clk where instrValid && instrReady.
REQ-019 On accepting opcode 00 or 01, the block SHALL register arg and set dc (1 for 00, 0 for 01), then enter LOAD on the next cycle.
REQ-020 In LOAD, cs SHALL be 0; pcEn SHALL be high only in the single clk cycle where sclkPosEdge = 1; LOAD then goes to SHIFT.
REQ-021 SHIFT SHALL keep cs = 0 and count DATA_W sclkPosEdge strobes; on the DATA_W-th strobe it SHALL return to IDLE.
REQ-022 A write SHALL therefore span exactly DATA_W+1 sclkPosEdge strobes from LOAD entry: 1 load plus DATA_W shifts.
REQ-023 On accepting opcode 10, the counter SHALL load arg and the block SHALL enter DELAY; each sclkPosEdge decrements the counter; on the strobe that takes it 1 -> 0, the block returns to IDLE.
REQ-024 On accepting opcode 11, the block SHALL behave as for DELAY, but in state RSTPULSE with resN = 0 throughout.
REQ-025 A DELAY or RSTPULSE with arg = 0 SHALL return to IDLE on the next clk cycle without waiting for sclkPosEdge; resN SHALL stay low for exactly one clk cycle in that case.
REQ-026 In IDLE, DELAY and RSTPULSE, cs SHALL be 1 and pcEn SHALL be 0.
REQ-027 dc SHALL hold its last written value outside LOAD and SHIFT.
REQ-028 Back-to-back writes SHALL insert exactly one IDLE cycle, so cs goes high for at least one clk between bytes.
REQ-029 instrValid while busy SHALL be ignored, and instr need not be held stable after acceptance.
REQ-030 If sclkPosEdge coincides with acceptance in IDLE, the strobe SHALL NOT be counted.
REQ-031 The counter SHALL never wrap; decrement is suppressed at 0.

Reset
REQ-032 While rst_n = 0, asynchronously: state = IDLE, counter = 0, registered arg = 0, cs = 1, dc = 0, pcEn = 0, resN = 1, busy = 0, instrReady = 0.
REQ-033 instrReady SHALL become 1 on the first posedge clk after rst_n deasserts.
REQ-034 Reset asserted mid-write, mid-delay or mid-pulse SHALL abort the operation immediately with no further pcEn pulse; resN SHALL return to 1.

Structure
REQ-035 The opcode constants, the state encoding and the DATA_W/ARG_W defaults SHALL live in a shared package (spi_display_pkg).
REQ-036 The tick counter (load, decrement on strobe, zero flag) SHALL be one sub-module, tick_down_counter, shared by SHIFT, DELAY and RSTPULSE.
REQ-037 No other sub-modules; serializer and clock divider remain external.

Verification
REQ-038 Write data: op 00, arg 0xAA, DATA_W = 8 -> dc = 1, cs = 0 for 9 strobes, one pcEn pulse, parallelData = 0xAA, then IDLE.
REQ-039 Write command: op 01, arg 0x33 immediately after REQ-038 -> exactly one IDLE cycle with cs = 1, then dc = 0, parallelData = 0x33.
REQ-040 Delay: op 10, arg 5 -> busy for exactly 5 strobes, cs = 1, no pcEn; arg 0 -> busy for exactly 1 clk.
REQ-041 Reset pulse: op 11, arg 3 -> resN = 0 for exactly 3 strobes, then 1; instrValid held during the pulse is ignored.
REQ-042 Mid-operation reset: rst_n low during SHIFT of the 4th bit -> cs = 1, pcEn = 0 and busy = 0 asynchronously; a new write after release completes normally.
REQ-043 Parameter sweep: DATA_W = 16, ARG_W = 20 -> a write spans 17 strobes and a delay of 0xFFFFF strobes completes without wrap.
